// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : button_conditioner
// Description : Per-button conditioning of raw active-low keys. Each channel
//               has a 2-FF synchronizer, a counter debouncer, press/release
//               edge pulses, long-press detection and auto-repeat pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module button_conditioner #(
  parameter int NUM_BTN         = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int LONG_CYCLES     = 50000000,
  parameter int REPEAT_CYCLES   = 10000000
) (
  input  logic               clk_clk,
  input  logic               reset_reset,
  input  logic [NUM_BTN-1:0] buttons_raw,
  output logic [NUM_BTN-1:0] buttons_level,
  output logic [NUM_BTN-1:0] press_pulse,
  output logic [NUM_BTN-1:0] release_pulse,
  output logic [NUM_BTN-1:0] long_pulse,
  output logic [NUM_BTN-1:0] repeat_pulse
);

  localparam int c_HOLD_MAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
  localparam int c_HOLD_W   = $clog2(c_HOLD_MAX + 1);
  localparam int c_DB_W     = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_REPEAT  = 2'd2
  } state_t;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
    logic [1:0]          r_sync;      // [1] is the synchronized key
    logic                r_level;
    logic [c_DB_W-1:0]   r_db_cnt;
    logic                w_accept;
    logic                w_fall;
    logic                w_rise;
    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_HOLD_W-1:0] r_hold;
    logic [c_HOLD_W-1:0] w_hold_nxt;
    logic                w_press;
    logic                w_release;
    logic                w_long;
    logic                w_repeat;
    logic                r_press;
    logic                r_release;
    logic                r_long;
    logic                r_repeat;

    // A change is accepted on the edge where the counter would reach DEBOUNCE_CYCLES.
    assign w_accept = (r_sync[1] != r_level) && (r_db_cnt == c_DB_W'(DEBOUNCE_CYCLES - 1));
    assign w_fall   = w_accept && r_level;
    assign w_rise   = w_accept && !r_level;

    // Synchronize the raw key and debounce it into the accepted level.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
        r_sync   <= 2'b11;
        r_level  <= 1'b1;
        r_db_cnt <= '0;
      end else begin
        r_sync <= {r_sync[0], buttons_raw[i]};
        if (r_sync[1] == r_level) begin
          r_db_cnt <= '0;
        end else if (w_accept) begin
          r_level  <= r_sync[1];
          r_db_cnt <= '0;
        end else begin
          r_db_cnt <= r_db_cnt + c_DB_W'(1);
        end
      end
    end

    // Hold-tracking state register and registered pulse outputs.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
        r_state   <= ST_IDLE;
        r_hold    <= '0;
        r_press   <= 1'b0;
        r_release <= 1'b0;
        r_long    <= 1'b0;
        r_repeat  <= 1'b0;
      end else begin
        r_state   <= w_state_nxt;
        r_hold    <= w_hold_nxt;
        r_press   <= w_press;
        r_release <= w_release;
        r_long    <= w_long;
        r_repeat  <= w_repeat;
      end
    end

    // Next-state logic; a release always wins over a same-cycle long/repeat.
    always_comb begin
      w_state_nxt = r_state;
      w_hold_nxt  = r_hold;
      w_press     = 1'b0;
      w_release   = 1'b0;
      w_long      = 1'b0;
      w_repeat    = 1'b0;
      if (w_rise) begin
        w_release   = 1'b1;
        w_hold_nxt  = '0;
        w_state_nxt = ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_fall) begin
              w_press     = 1'b1;
              w_hold_nxt  = '0;
              w_state_nxt = ST_PRESSED;
            end
          end
          ST_PRESSED: begin
            if (r_hold == c_HOLD_W'(LONG_CYCLES - 1)) begin
              w_long      = 1'b1;
              w_hold_nxt  = '0;
              w_state_nxt = ST_REPEAT;
            end else begin
              w_hold_nxt = r_hold + c_HOLD_W'(1);
            end
          end
          ST_REPEAT: begin
            if (r_hold == c_HOLD_W'(REPEAT_CYCLES - 1)) begin
              w_repeat   = 1'b1;
              w_hold_nxt = '0;
            end else begin
              w_hold_nxt = r_hold + c_HOLD_W'(1);
            end
          end
          default: begin
            w_hold_nxt  = '0;
            w_state_nxt = ST_IDLE;
          end
        endcase
      end
    end

    assign buttons_level[i] = r_level;
    assign press_pulse[i]   = r_press;
    assign release_pulse[i] = r_release;
    assign long_pulse[i]    = r_long;
    assign repeat_pulse[i]  = r_repeat;
  end

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_conditioner
// Description : Self-checking bench for button_conditioner: directed vector
//               table, hand-written latency/reset sequences, and random keys
//               checked every cycle against a timestamp-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_conditioner;
  localparam int NB   = 2;
  localparam int DB   = 4;
  localparam int LG   = 20;
  localparam int RP   = 5;
  localparam int HMAX = 8192;

  logic          clk = 1'b0;
  logic          rst;
  logic [NB-1:0] raw;
  logic [NB-1:0] level, press, rel, lng, rep;

  button_conditioner #(
    .NUM_BTN(NB), .DEBOUNCE_CYCLES(DB), .LONG_CYCLES(LG), .REPEAT_CYCLES(RP)
  ) dut (
    .clk_clk(clk), .reset_reset(rst), .buttons_raw(raw),
    .buttons_level(level), .press_pulse(press), .release_pulse(rel),
    .long_pulse(lng), .repeat_pulse(rep)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: raw samples by edge index since reset, press timestamps.
  logic [NB-1:0] rh [0:HMAX-1];
  int            n;
  int            press_t [NB];
  logic [NB-1:0] m_level, m_press, m_rel, m_long, m_rep;

  // Pulse tallies of the DUT outputs over a table segment.
  int cp [NB];
  int cr [NB];
  int cl [NB];
  int cq [NB];

  typedef struct {
    logic [NB-1:0] raw;
    int            cycles;
    logic [NB-1:0] lvl;
    logic [7:0]    p;  // expected counts {ch1, ch0} nibbles
    logic [7:0]    r;
    logic [7:0]    l;
    logic [7:0]    q;
  } vec_t;
  vec_t tbl [13];

  logic [NB-1:0] rv;
  int            left [NB];
  int            lat;

  function automatic logic raw_at(input int idx, input int c);
    return (idx < 1) ? 1'b1 : rh[idx][c];
  endfunction

  task automatic model_reset();
    n       = 0;
    m_level = '1;
    m_press = '0; m_rel = '0; m_long = '0; m_rep = '0;
    for (int c = 0; c < NB; c++) press_t[c] = -1;
  endtask

  // One clock edge: level flips once the synchronized key (raw two edges
  // earlier) has disagreed with it for DB consecutive edges; pulses follow
  // from the time elapsed since the press.
  task automatic model_step();
    bit all_diff;
    int d;
    n++;
    if (n >= HMAX) begin
      $display("FAIL model_history at %0t: got n=%0d want below %0d", $time, n, HMAX);
      $fatal(1);
    end
    rh[n] = raw;
    for (int c = 0; c < NB; c++) begin
      m_press[c] = 1'b0; m_rel[c] = 1'b0; m_long[c] = 1'b0; m_rep[c] = 1'b0;
      all_diff = 1'b1;
      for (int j = n - DB - 1; j <= n - 2; j++)
        if (raw_at(j, c) == m_level[c]) all_diff = 1'b0;
      if (all_diff) begin
        m_level[c] = ~m_level[c];
        if (!m_level[c]) begin
          m_press[c] = 1'b1;
          press_t[c] = n;
        end else begin
          m_rel[c]   = 1'b1;
          press_t[c] = -1;
        end
      end else if (press_t[c] >= 0) begin
        d = n - press_t[c];
        if (d == LG) m_long[c] = 1'b1;
        else if (d > LG && ((d - LG) % RP) == 0) m_rep[c] = 1'b1;
      end
    end
  endtask

  task automatic chk(input string nm, input logic [NB-1:0] act, input logic [NB-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %b want %b", nm, $time, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d want %0d", nm, $time, act, exp);
    end
  endtask

  task automatic check_all();
    chk("level",   level, m_level);
    chk("press",   press, m_press);
    chk("release", rel,   m_rel);
    chk("long",    lng,   m_long);
    chk("repeat",  rep,   m_rep);
  endtask

  task automatic clear_counts();
    for (int c = 0; c < NB; c++) begin
      cp[c] = 0; cr[c] = 0; cl[c] = 0; cq[c] = 0;
    end
  endtask

  // Drive raw for one cycle, step the model at the edge, check at the negedge.
  task automatic tick(input logic [NB-1:0] r);
    raw = r;
    @(posedge clk);
    if (!rst) model_step();
    @(negedge clk);
    check_all();
    for (int c = 0; c < NB; c++) begin
      cp[c] += int'(press[c]);
      cr[c] += int'(rel[c]);
      cl[c] += int'(lng[c]);
      cq[c] += int'(rep[c]);
    end
  endtask

  // Hold raw and return the number of edges until the chosen pulse, -1 on timeout.
  task automatic wait_pulse(input logic [NB-1:0] r, input int ch, input bit want_press,
                            output int edges);
    edges = -1;
    for (int i = 1; i <= 20; i++) begin
      tick(r);
      if ((want_press ? press[ch] : rel[ch]) === 1'b1) begin
        edges = i;
        break;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog at %0t: got timeout want completion", $time);
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{2'b11, 10, 2'b11, 8'h00, 8'h00, 8'h00, 8'h00};
    tbl[1]  = '{2'b10,  6, 2'b10, 8'h01, 8'h00, 8'h00, 8'h00};
    tbl[2]  = '{2'b10, 60, 2'b10, 8'h00, 8'h00, 8'h01, 8'h08};
    tbl[3]  = '{2'b11,  6, 2'b11, 8'h00, 8'h01, 8'h00, 8'h01};
    tbl[4]  = '{2'b11,  4, 2'b11, 8'h00, 8'h00, 8'h00, 8'h00};
    tbl[5]  = '{2'b01,  3, 2'b11, 8'h00, 8'h00, 8'h00, 8'h00};
    tbl[6]  = '{2'b11, 10, 2'b11, 8'h00, 8'h00, 8'h00, 8'h00};
    tbl[7]  = '{2'b01, 10, 2'b01, 8'h10, 8'h00, 8'h00, 8'h00};
    tbl[8]  = '{2'b11,  8, 2'b11, 8'h00, 8'h10, 8'h00, 8'h00};
    tbl[9]  = '{2'b00,  6, 2'b00, 8'h11, 8'h00, 8'h00, 8'h00};
    tbl[10] = '{2'b00, 16, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00};
    tbl[11] = '{2'b10, 20, 2'b10, 8'h00, 8'h10, 8'h11, 8'h03};
    tbl[12] = '{2'b11, 10, 2'b11, 8'h00, 8'h01, 8'h00, 8'h01};

    rst = 1'b1;
    raw = '1;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    rst = 1'b0;

    // Directed vector table.
    for (int i = 0; i < 13; i++) begin
      clear_counts();
      for (int k = 0; k < tbl[i].cycles; k++) tick(tbl[i].raw);
      chk($sformatf("vec%0d_level", i), level, tbl[i].lvl);
      chk_int($sformatf("vec%0d_press", i),   {24'd0, 4'(cp[1]), 4'(cp[0])}, int'(tbl[i].p));
      chk_int($sformatf("vec%0d_release", i), {24'd0, 4'(cr[1]), 4'(cr[0])}, int'(tbl[i].r));
      chk_int($sformatf("vec%0d_long", i),    {24'd0, 4'(cl[1]), 4'(cl[0])}, int'(tbl[i].l));
      chk_int($sformatf("vec%0d_repeat", i),  {24'd0, 4'(cq[1]), 4'(cq[0])}, int'(tbl[i].q));
    end

    // Exact raw-to-pulse latency on press and release.
    wait_pulse(2'b10, 0, 1'b1, lat);
    chk_int("press_latency", lat, 2 + DB);
    wait_pulse(2'b11, 0, 1'b0, lat);
    chk_int("release_latency", lat, 2 + DB);

    // Reset asserted mid-repeat, key held across the reset release.
    for (int k = 0; k < 6 + LG + RP + 2; k++) tick(2'b10);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("reset_level", level, 2'b11);
    chk("reset_pulses", press | rel | lng | rep, 2'b00);
    @(negedge clk);
    for (int k = 0; k < 3; k++) tick(2'b10);
    rst = 1'b0;
    wait_pulse(2'b10, 0, 1'b1, lat);
    chk_int("press_after_reset", lat, 2 + DB);

    // Random keys against the reference model.
    rv = '1;
    for (int c = 0; c < NB; c++) left[c] = 0;
    for (int cyc = 0; cyc < 2500; cyc++) begin
      for (int c = 0; c < NB; c++) begin
        if (left[c] == 0) begin
          rv[c]   = 1'($urandom_range(0, 1));
          left[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(25, 70))
                                                : int'($urandom_range(1, 8));
        end
        left[c]--;
      end
      tick(rv);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
